// File: rtl/key_entry_ctrl_pkg.sv
// Shared key codes, operator/display encodings and FSM states for the
// keypad entry sequencer and its debouncer.
package key_entry_ctrl_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_code_e;

  typedef enum logic [1:0] {
    ENTER_A   = 2'd0,
    ENTER_B   = 2'd1,
    WAIT_CALC = 2'd2,
    SHOW_RES  = 2'd3
  } entry_state_e;

  typedef enum logic [1:0] {
    DISP_A   = 2'd0,
    DISP_B   = 2'd1,
    DISP_RES = 2'd2
  } disp_sel_e;

  typedef enum logic {
    DB_ARMED   = 1'b0,
    DB_PRESSED = 1'b1
  } db_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  function automatic op_code_e key_to_op(input logic [3:0] code);
    op_code_e op;
    case (code)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // WAIT_CALC keeps showing operand B until the result arrives.
  function automatic disp_sel_e disp_for_state(input entry_state_e st);
    disp_sel_e ds;
    case (st)
      ENTER_A:   ds = DISP_A;
      ENTER_B:   ds = DISP_B;
      WAIT_CALC: ds = DISP_B;
      SHOW_RES:  ds = DISP_RES;
      default:   ds = DISP_A;
    endcase
    return ds;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns the scanner's raw KeyRead/BCDKey pair into one-cycle key events:
// a press must be stable for DB_CYCLES cycles, and so must the release.
module key_debounce
  import key_entry_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       KeyRead,
  input  logic [3:0] BCDKey,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  db_state_e     state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    prev_code_r;
  logic          evt_s;
  logic          key_evt_r;
  logic [3:0]    key_code_r;

  // Next-state logic; prev_code_r holds the code that was stable when the count filled.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    evt_s   = 1'b0;
    case (state_r)
      DB_ARMED: begin
        if (cnt_r == CNT_MAX) begin
          evt_s   = 1'b1;
          state_s = DB_PRESSED;
          cnt_s   = '0;
        end else if (KeyRead && (BCDKey == prev_code_r)) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = '0;
        end
      end
      DB_PRESSED: begin
        if (cnt_r == CNT_MAX) begin
          state_s = DB_ARMED;
          cnt_s   = '0;
        end else if (!KeyRead) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = '0;
        end
      end
      default: begin
        state_s = DB_ARMED;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter and event registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= DB_ARMED;
      cnt_r       <= '0;
      prev_code_r <= 4'd0;
      key_evt_r   <= 1'b0;
      key_code_r  <= 4'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      prev_code_r <= BCDKey;
      key_evt_r   <= evt_s;
      if (evt_s) begin
        key_code_r <= prev_code_r;
      end
    end
  end

  assign key_evt  = key_evt_r;
  assign key_code = key_code_r;

endmodule

// File: rtl/key_entry_ctrl.sv
// Calculator key-entry sequencer: builds BCD operands and an operator from
// debounced key events, launches the arithmetic unit and selects the display.
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int NDIGITS   = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 KeyRead,
  input  logic [3:0]           BCDKey,
  output logic                 EnableKeyb,
  output logic                 calc_start,
  input  logic                 calc_done,
  input  logic [4*NDIGITS-1:0] calc_result,
  output logic [4*NDIGITS-1:0] operand_a,
  output logic [4*NDIGITS-1:0] operand_b,
  output logic [1:0]           op_code,
  output logic [1:0]           disp_sel
);

  localparam int W    = 4 * NDIGITS;
  localparam int CNTW = $clog2(NDIGITS + 1);
  localparam logic [CNTW-1:0] NDIG = CNTW'(NDIGITS);

  logic            key_evt_s;
  logic [3:0]      key_code_s;
  entry_state_e    state_r, state_s;
  logic [W-1:0]    a_r, a_s, b_r, b_s, res_r, res_s;
  logic [CNTW-1:0] cnt_a_r, cnt_a_s, cnt_b_r, cnt_b_s;
  op_code_e        op_r, op_s;
  logic            start_s;
  logic            start_r;
  logic            enable_r;
  disp_sel_e       disp_r;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .KeyRead  (KeyRead),
    .BCDKey   (BCDKey),
    .key_evt  (key_evt_s),
    .key_code (key_code_s)
  );

  // Entry FSM next-state and datapath; acts only on key_evt (or calc_done in WAIT_CALC).
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    res_s   = res_r;
    cnt_a_s = cnt_a_r;
    cnt_b_s = cnt_b_r;
    op_s    = op_r;
    start_s = 1'b0;
    case (state_r)
      ENTER_A: begin
        if (!key_evt_s) begin
          state_s = state_r;
        end else if (is_digit(key_code_s)) begin
          if (cnt_a_r < NDIG) begin
            a_s     = {a_r[W-5:0], key_code_s};
            cnt_a_s = cnt_a_r + CNTW'(1);
          end else begin
            a_s = a_r;
          end
        end else if (is_operator(key_code_s)) begin
          op_s    = key_to_op(key_code_s);
          b_s     = '0;
          cnt_b_s = '0;
          state_s = ENTER_B;
        end else if (key_code_s == KEY_CLR) begin
          a_s     = '0;
          cnt_a_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      ENTER_B: begin
        if (!key_evt_s) begin
          state_s = state_r;
        end else if (is_digit(key_code_s)) begin
          if (cnt_b_r < NDIG) begin
            b_s     = {b_r[W-5:0], key_code_s};
            cnt_b_s = cnt_b_r + CNTW'(1);
          end else begin
            b_s = b_r;
          end
        end else if (is_operator(key_code_s)) begin
          // Operator may only be changed before any B digit is typed.
          if (cnt_b_r == '0) begin
            op_s = key_to_op(key_code_s);
          end else begin
            op_s = op_r;
          end
        end else if (key_code_s == KEY_EQ) begin
          if (cnt_b_r != '0) begin
            start_s = 1'b1;
            state_s = WAIT_CALC;
          end else begin
            state_s = state_r;
          end
        end else begin
          a_s     = '0;
          b_s     = '0;
          cnt_a_s = '0;
          cnt_b_s = '0;
          op_s    = OP_ADD;
          state_s = ENTER_A;
        end
      end
      WAIT_CALC: begin
        if (calc_done) begin
          res_s   = calc_result;
          state_s = SHOW_RES;
        end else begin
          state_s = state_r;
        end
      end
      SHOW_RES: begin
        if (!key_evt_s) begin
          state_s = state_r;
        end else if (is_digit(key_code_s)) begin
          a_s     = W'(key_code_s);
          cnt_a_s = CNTW'(1);
          state_s = ENTER_A;
        end else if (is_operator(key_code_s)) begin
          a_s     = res_r;
          cnt_a_s = NDIG;
          op_s    = key_to_op(key_code_s);
          b_s     = '0;
          cnt_b_s = '0;
          state_s = ENTER_B;
        end else if (key_code_s == KEY_CLR) begin
          a_s     = '0;
          b_s     = '0;
          res_s   = '0;
          cnt_a_s = '0;
          cnt_b_s = '0;
          op_s    = OP_ADD;
          state_s = ENTER_A;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ENTER_A;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= ENTER_A;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      cnt_a_r  <= '0;
      cnt_b_r  <= '0;
      op_r     <= OP_ADD;
      start_r  <= 1'b0;
      enable_r <= 1'b0;
      disp_r   <= DISP_A;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      res_r    <= res_s;
      cnt_a_r  <= cnt_a_s;
      cnt_b_r  <= cnt_b_s;
      op_r     <= op_s;
      start_r  <= start_s;
      enable_r <= (state_s != WAIT_CALC);
      disp_r   <= disp_for_state(state_s);
    end
  end

  assign operand_a  = a_r;
  assign operand_b  = b_r;
  assign op_code    = op_r;
  assign calc_start = start_r;
  assign EnableKeyb = enable_r;
  assign disp_sel   = disp_r;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl: scenario tasks push expected output
// snapshots into a scoreboard queue and pop them when the DUT has responded.
module tb_key_entry_ctrl;
  import key_entry_ctrl_pkg::*;

  localparam int NDIGITS = 4;
  localparam int DB      = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        KeyRead = 1'b0;
  logic [3:0]  BCDKey = 4'd0;
  logic        calc_done = 1'b0;
  logic [15:0] calc_result = 16'h0000;
  logic        EnableKeyb, calc_start;
  logic [15:0] operand_a, operand_b;
  logic [1:0]  op_code, disp_sel;

  always #5 CLK = ~CLK;

  key_entry_ctrl #(.NDIGITS(NDIGITS), .DB_CYCLES(DB)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .KeyRead     (KeyRead),
    .BCDKey      (BCDKey),
    .EnableKeyb  (EnableKeyb),
    .calc_start  (calc_start),
    .calc_done   (calc_done),
    .calc_result (calc_result),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_code     (op_code),
    .disp_sel    (disp_sel)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int start_long = 0;
  int evt_cnt = 0;
  logic start_prev = 1'b0;

  logic [36:0] exp_q[$];
  string       name_q[$];
  logic [36:0] exp_v;
  string       nm;
  wire  [36:0] obs_v = {operand_a, operand_b, op_code, disp_sel, EnableKeyb};

  // Monitor: count calc_start pulses, over-long pulses and debounced events.
  always @(negedge CLK) begin
    if (calc_start) start_cnt++;
    if (calc_start && start_prev) start_long++;
    start_prev = calc_start;
    if (dut.u_debounce.key_evt) evt_cnt++;
  end

  function automatic logic [36:0] mk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [1:0] op, input logic [1:0] ds,
                                     input logic en);
    return {a, b, op, ds, en};
  endfunction

  task automatic press_key(input logic [3:0] code);
    @(negedge CLK);
    BCDKey  = code;
    KeyRead = 1'b0;
    @(negedge CLK);
    KeyRead = 1'b1;
    repeat (DB + 5) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (DB + 5) @(negedge CLK);
  endtask

  task automatic wait_key_evt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (dut.u_debounce.key_evt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    exp_q.push_back(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0)); name_q.push_back("reset_hold");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    RESET_N = 1'b1;
    #1;
    exp_q.push_back(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0)); name_q.push_back("pre_first_edge");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    @(negedge CLK);
    exp_q.push_back(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("first_edge_enable");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  task automatic test_single_key;
    int lat;
    int e0;
    e0 = evt_cnt;
    @(negedge CLK);
    BCDKey = 4'd7;
    @(negedge CLK);
    KeyRead = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      lat++;
      if (dut.u_debounce.key_evt) break;
    end
    checks++;
    if (lat != DB + 1) begin errors++; $display("FAIL press_latency got=%0d want=%0d", lat, DB + 1); end
    repeat (4) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (DB + 5) @(negedge CLK);
    checks++;
    if (evt_cnt - e0 != 1) begin errors++; $display("FAIL held_key_events got=%0d want=1", evt_cnt - e0); end
    exp_q.push_back(mk(16'h0007, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("single_key_7");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  task automatic test_bounce;
    int e0;
    e0 = evt_cnt;
    @(negedge CLK);
    BCDKey = 4'd3;
    for (int i = 0; i < 40; i++) begin
      KeyRead = ((i / 3) % 2 == 0);
      @(negedge CLK);
    end
    checks++;
    if (evt_cnt != e0) begin errors++; $display("FAIL bounce_events got=%0d want=0", evt_cnt - e0); end
    KeyRead = 1'b1;
    repeat (DB + 5) @(negedge CLK);
    KeyRead = 1'b0;
    repeat (DB + 5) @(negedge CLK);
    checks++;
    if (evt_cnt - e0 != 1) begin errors++; $display("FAIL bounce_stable_events got=%0d want=1", evt_cnt - e0); end
    exp_q.push_back(mk(16'h0073, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("bounce_digit_3");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  task automatic test_calc;
    int s0;
    press_key(KEY_CLR);
    s0 = start_cnt;
    press_key(4'd1);
    press_key(4'd2);
    press_key(KEY_ADD);
    press_key(4'd3);
    press_key(4'd4);
    press_key(KEY_EQ);
    exp_q.push_back(mk(16'h0012, 16'h0034, 2'd0, 2'd1, 1'b0)); name_q.push_back("calc_wait");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL calc_start_count got=%0d want=1", start_cnt - s0); end
    checks++;
    if (start_long != 0) begin errors++; $display("FAIL calc_start_width got=%0d want=0", start_long); end
    calc_result = 16'h0046;
    calc_done   = 1'b1;
    @(negedge CLK);
    calc_done = 1'b0;
    exp_q.push_back(mk(16'h0012, 16'h0034, 2'd0, 2'd2, 1'b1)); name_q.push_back("calc_show_res");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  task automatic test_overflow;
    press_key(KEY_CLR);
    calc_result = 16'h5555;
    calc_done   = 1'b1;
    @(negedge CLK);
    calc_done = 1'b0;
    @(negedge CLK);
    exp_q.push_back(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("clear_and_done_ignored");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    for (int d = 1; d <= 5; d++) press_key(4'(d));
    exp_q.push_back(mk(16'h1234, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("fifth_digit_dropped");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    press_key(KEY_SUB);
    exp_q.push_back(mk(16'h1234, 16'h0000, 2'd1, 2'd1, 1'b1)); name_q.push_back("op_sub");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    press_key(KEY_SUB);
    press_key(KEY_MUL);
    exp_q.push_back(mk(16'h1234, 16'h0000, 2'd2, 2'd1, 1'b1)); name_q.push_back("op_replaced_mul");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  task automatic test_wait_clear_done;
    int s0;
    bit ok;
    s0 = start_cnt;
    press_key(KEY_EQ);
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL eq_empty_b_start got=%0d want=0", start_cnt - s0); end
    press_key(4'd5);
    press_key(KEY_EQ);
    exp_q.push_back(mk(16'h1234, 16'h0005, 2'd2, 2'd1, 1'b0)); name_q.push_back("wait_calc_2");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    @(negedge CLK);
    BCDKey = KEY_CLR;
    @(negedge CLK);
    KeyRead = 1'b1;
    wait_key_evt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clr_evt_timeout got=0 want=1"); end
    calc_result = 16'h0987;
    calc_done   = 1'b1;
    @(negedge CLK);
    calc_done = 1'b0;
    KeyRead   = 1'b0;
    repeat (DB + 5) @(negedge CLK);
    exp_q.push_back(mk(16'h1234, 16'h0005, 2'd2, 2'd2, 1'b1)); name_q.push_back("clear_ignored_done_taken");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    press_key(KEY_MUL);
    exp_q.push_back(mk(16'h0987, 16'h0000, 2'd2, 2'd1, 1'b1)); name_q.push_back("chain_result");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  task automatic test_async_reset;
    int s0;
    bit ok;
    press_key(4'd6);
    exp_q.push_back(mk(16'h0987, 16'h0006, 2'd2, 2'd1, 1'b1)); name_q.push_back("partial_b");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    @(negedge CLK);
    BCDKey = KEY_EQ;
    @(negedge CLK);
    KeyRead = 1'b1;
    wait_key_evt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL eq_evt_timeout got=0 want=1"); end
    s0 = start_cnt;
    #2;
    RESET_N = 1'b0;
    #1;
    exp_q.push_back(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0)); name_q.push_back("async_clear");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    KeyRead = 1'b0;
    @(negedge CLK);
    #2;
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL pending_start_issued got=%0d want=0", start_cnt - s0); end
    exp_q.push_back(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("post_reset");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
    press_key(4'd8);
    exp_q.push_back(mk(16'h0008, 16'h0000, 2'd0, 2'd0, 1'b1)); name_q.push_back("rearmed_digit_8");
    exp_v = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL %s got=%h want=%h", nm, obs_v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_calc();
    test_overflow();
    test_wait_clear_done();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=expired want=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
- Sequencer between the matrix-keypad scanner and the calculator arithmetic unit.
- Debounces the scanner's KeyRead/BCDKey pair into single key events.
- Assembles BCD operands and an operator from those events, then launches a calculation and waits for it to finish.
- Gates the scanner through EnableKeyb and selects what the display shows.

Parameters:
NDIGITS, 4, BCD digits per operand (operand width = 4*NDIGITS)
DB_CYCLES, 16, consecutive stable CLK cycles required to qualify a press or a release (>=1)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
KeyRead  in  1  scanner reports a key held
BCDKey  in  4  scanner key code; 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear
EnableKeyb  out  1  enables scanner polling
calc_start  out  1  one-cycle pulse launching the arithmetic unit
calc_done  in  1  one-cycle pulse, result valid
calc_result  in  4*NDIGITS  BCD result, sampled when calc_done=1
operand_a  out  4*NDIGITS  first operand, BCD
operand_b  out  4*NDIGITS  second operand, BCD
op_code  out  2  0 add, 1 sub, 2 mul, 3 div
disp_sel  out  2  0 show operand_a, 1 show operand_b, 2 show calc_result

Behaviour:
- Single clock domain. Every register clears asynchronously while RESET_N=0.
- Reset values: operands 0, op_code 0, calc_start 0, disp_sel 0, EnableKeyb 0, FSM in ENTER_A, debouncer idle.
- EnableKeyb is registered. It goes to 1 on the first CLK edge after reset release while the FSM is not in WAIT_CALC, and is 0 in WAIT_CALC.
- Debouncer (ARMED/PRESSED):
  - ARMED: counts cycles with KeyRead=1 and BCDKey equal to the previous cycle's value. A change in code or KeyRead=0 reloads the counter.
  - When the count reaches DB_CYCLES, key_evt pulses for exactly 1 cycle with key_code latched, and the debouncer moves to PRESSED.
  - PRESSED: DB_CYCLES consecutive cycles of KeyRead=0 return it to ARMED. A key held indefinitely gives exactly one event.
  - Latency from a stable press to key_evt: DB_CYCLES+1 cycles.
- Entry FSM states: ENTER_A, ENTER_B, WAIT_CALC, SHOW_RES. It acts only on a key_evt cycle.
- Digit shift-in: operand <= {operand[4*NDIGITS-5:0], code}; the digit count for that operand increments.
  - Digits beyond NDIGITS are discarded; operand and count stay unchanged.
- ENTER_A (disp_sel=0):
  - digit -> shift into A.
  - operator -> latch op_code, clear B and its count, go to ENTER_B. Empty A is allowed (value 0).
  - '=' -> ignored.
  - clear -> A=0, count 0.
- ENTER_B (disp_sel=1):
  - digit -> shift into B.
  - operator with B count 0 -> replace op_code. Operator with B count >0 -> ignored.
  - '=' with B count >0 -> calc_start=1 for the next cycle only, go to WAIT_CALC. '=' with B count 0 -> ignored.
  - clear -> A, B, counts, op_code = 0; go to ENTER_A.
- WAIT_CALC (disp_sel holds 1):
  - All key events are discarded, including clear.
  - calc_done -> go to SHOW_RES with disp_sel=2.
  - key_evt and calc_done in the same cycle: the key is discarded and done is taken.
  - No timeout.
- SHOW_RES (disp_sel=2):
  - digit -> A = that digit (count 1), go to ENTER_A.
  - operator -> A = calc_result (count NDIGITS), latch op_code, clear B, go to ENTER_B. This chains the result.
  - '=' -> ignored.
  - clear -> all zero, go to ENTER_A.
- calc_done outside WAIT_CALC is ignored.
- Mid-operation reset aborts everything: a pending calc_start never issues, and the debouncer re-arms.

Decomposition:
- Shared package holds:
  - key code constants KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_DIV=13, KEY_EQ=14, KEY_CLR=15.
  - op_code encodings.
  - FSM state encodings.
  - disp_sel encodings.
- One sub-module: key_debounce (CLK, RESET_N, KeyRead, BCDKey -> key_evt, key_code), parameterised by DB_CYCLES.

Test Plan:
- Reset release, KeyRead held 1 with BCDKey=7 for DB_CYCLES+5 cycles, then 0 -> exactly one key_evt; operand_a=0x0007; EnableKeyb=1 from the first post-reset edge.
- Bounce: KeyRead toggles every 3 cycles (DB_CYCLES=16) for 40 cycles, then holds high with code 3 -> a single event after the stable run; operand_a gains digit 3 only.
- Keys 1,2,'+',3,4,'=' -> operand_a=0x0012, operand_b=0x0034, op_code=0, one 1-cycle calc_start, EnableKeyb=0; calc_done with result 0x0046 -> disp_sel=2, EnableKeyb=1.
- NDIGITS=4, digits 1,2,3,4,5 -> operand_a=0x1234, fifth digit dropped; then '-','-','*' with B empty -> op_code=2.
- In WAIT_CALC, clear key and calc_done in the same cycle -> clear ignored, SHOW_RES entered; then '*' -> operand_a=calc_result, state ENTER_B.
- RESET_N pulsed low for 1 cycle in ENTER_B with partial B -> all outputs at reset values immediately (asynchronous), FSM in ENTER_A.
